// File: rtl/bcd_counter_3dig.sv
// Three-digit BCD up/down event counter for the 7-segment display path.
// Advances on a prescaled tick or a synchronized STEP edge; clear and load take priority.
module bcd_counter_3dig #(
  parameter int unsigned TICK_DIV = 100_000_000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic        UP,
  input  logic        CLR,
  input  logic        LOAD,
  input  logic [11:0] LOAD_VAL,
  input  logic        STEP,
  output logic [3:0]  units,
  output logic [3:0]  tens,
  output logic [3:0]  hundreds,
  output logic        TC
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]   presc_q, presc_d;
  logic [2:0]      sync_q, sync_d;   // {s3, s2, s1}
  logic [2:0][3:0] dig_q, dig_d;
  logic            tc_q, tc_d;

  logic            tick, step_rise, advance;
  logic [3:0]      cy;               // carry (up) or borrow (down) into each digit
  logic [2:0][3:0] nxt;

  always_comb begin
    tick      = EN && (presc_q == PRESC_MAX);
    step_rise = sync_q[1] & ~sync_q[2];
    advance   = tick | step_rise;
    sync_d    = {sync_q[1], sync_q[0], STEP};

    presc_d = presc_q;
    if (EN) presc_d = tick ? '0 : presc_q + PW'(1);
    if (CLR) presc_d = '0;

    cy[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt[i]  = dig_q[i];
      cy[i+1] = 1'b0;
      if (cy[i]) begin
        if (UP) begin
          if (dig_q[i] >= 4'd9) begin
            nxt[i]  = 4'd0;
            cy[i+1] = 1'b1;
          end else begin
            nxt[i] = dig_q[i] + 4'd1;
          end
        end else begin
          if (dig_q[i] == 4'd0) begin
            nxt[i]  = 4'd9;
            cy[i+1] = 1'b1;
          end else begin
            nxt[i] = dig_q[i] - 4'd1;
          end
        end
      end
    end

    dig_d = dig_q;
    tc_d  = 1'b0;
    if (CLR) begin
      dig_d = '0;
    end else if (LOAD) begin
      // Non-BCD load nibbles clamp to 9 so the digits never leave 0-9
      for (int i = 0; i < 3; i++)
        dig_d[i] = (LOAD_VAL[4*i +: 4] > 4'd9) ? 4'd9 : LOAD_VAL[4*i +: 4];
    end else if (advance) begin
      dig_d = nxt;
      tc_d  = cy[3];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_q <= '0;
      sync_q  <= '0;
      dig_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sync_q  <= sync_d;
      dig_q   <= dig_d;
      tc_q    <= tc_d;
    end
  end

  assign units    = dig_q[0];
  assign tens     = dig_q[1];
  assign hundreds = dig_q[2];
  assign TC       = tc_q;

endmodule

// File: doc/bcd_counter_3dig.md
# bcd_counter_3dig

Three-digit BCD event counter (000–999) that produces the `units`, `tens` and `hundreds` nibbles consumed by the multiplexed 7-segment display driver. Advances on an internal prescaled tick or on a synchronized manual `STEP` pulse, counts up or down, and supports synchronous clear and parallel BCD load. All outputs are registered, so the display stage samples stable, glitch-free digits.

## Interface

- `TICK_DIV`, default 100_000_000: CLK cycles per automatic count tick (1 Hz at 100 MHz); legal range ≥ 2.
- `CLK`  input  1  system clock, all logic on rising edge.
- `RST_N`  input  1  reset, asynchronous, active-low.
- `EN`  input  1  enables prescaler and automatic advance.
- `UP`  input  1  direction: 1 = increment, 0 = decrement (applies to tick and STEP).
- `CLR`  input  1  synchronous clear of digits and prescaler.
- `LOAD`  input  1  synchronous parallel load from `LOAD_VAL`.
- `LOAD_VAL`  input  12  BCD load value {hundreds, tens, units}.
- `STEP`  input  1  asynchronous manual step request (debounced externally), one advance per rising edge.
- `units`  output  4  BCD units digit, registered.
- `tens`  output  4  BCD tens digit, registered.
- `hundreds`  output  4  BCD hundreds digit, registered.
- `TC`  output  1  terminal-count pulse, registered, one cycle wide.

## Operation

- Reset (`RST_N`=0, asynchronous): `units`=`tens`=`hundreds`=0, `TC`=0, prescaler=0, STEP sync flops (s1, s2, s3)=0.
- Prescaler: width ceil(log2(TICK_DIV)). When `EN`=1: tick=(presc==TICK_DIV-1); on tick presc←0, else presc+1. When `EN`=0: presc holds, tick=0.
- STEP path: two-flop synchronizer s1→s2, then history flop s3; step_rise = s2 & ~s3. Not gated by `EN`.
- advance = tick | step_rise. Coincident tick and step_rise produce exactly one advance.
- Priority per cycle: `CLR` > `LOAD` > advance > hold.
  - `CLR`: digits←000, presc←0, `TC`←0.
  - `LOAD`: each nibble of `LOAD_VAL` > 9 saturates to 9; digits←result; presc continues normally; `TC`←0.
  - advance, `UP`=1: ripple-carry BCD increment; digit 9→0 carries into next; 999→000 and `TC`←1.
  - advance, `UP`=0: BCD decrement with borrow; digit 0→9 borrows; 000→999 and `TC`←1.
  - otherwise: digits hold, `TC`←0.
- A step_rise or tick lost to `CLR`/`LOAD` in the same cycle is discarded, not queued.
- Digits are always valid BCD (0–9) after reset; no state produces values 10–15.

## Timing

- Automatic count: with `EN`=1 continuously from reset release, first advance on the TICK_DIV-th rising edge, then every TICK_DIV edges.
- `EN` deasserted: prescaler freezes; on re-enable, counting resumes from frozen value (no restart).
- STEP latency: if edge k is the first to sample `STEP`=1, digits change at edge k+2. `STEP` must stay high ≥1 cycle and low ≥1 cycle between requests; held high = single advance.
- `CLR`/`LOAD`: digits update on the same edge that samples the control high (1-cycle latency, visible next cycle).
- `TC`: high for exactly the one cycle following the wrap edge; two wraps in consecutive cycles (STEP at boundary) give `TC` high two cycles.
- Reset mid-operation: all state returns to reset values immediately; first edge after `RST_N` rises counts as prescaler cycle 1.

## Test plan

- Reset/auto count, TICK_DIV=4, `EN`=1, `UP`=1: digits 000 after reset; 001 after edge 4, 002 after edge 8; `TC`=0 throughout.
- Up wrap: `LOAD` 0x998, `UP`=1, two ticks → 999 then 000; `TC`=1 for exactly one cycle after 999→000; 099→100 and 009→010 carries checked.
- Down wrap/borrow: `LOAD` 0x001, `UP`=0 → 000 then 999 with `TC` pulse; `LOAD` 0x100 then one tick → 099.
- STEP: `EN`=0, pulse `STEP` high 5 cycles at edge k → single advance visible after edge k+2, prescaler unchanged; STEP coincident with tick → exactly +1.
- Priority/saturation: `CLR`, `LOAD`, tick same cycle → 000, presc=0; `LOAD` 0xAF3 → 993; `LOAD` with tick → loaded value, no advance.
- Async reset: assert `RST_N`=0 mid-count at 457 between edges → outputs 000, `TC`=0 immediately without clock edge.
